// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-address generator: next-PC select codes,
// sequential step sizes and the redirect-target alignment check.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_RESET    = 3'd0,
        SEL_TRAP     = 3'd1,
        SEL_REDIRECT = 3'd2,
        SEL_HOLD     = 3'd3,
        SEL_RAS      = 3'd4,
        SEL_SEQ      = 3'd5
    } pc_sel_e;

    localparam logic [2:0] STEP_2 = 3'd2;
    localparam logic [2:0] STEP_4 = 3'd4;

    // A target is unusable if it is odd, or not word aligned when only 32-bit instructions exist.
    function automatic logic addr_misaligned(input logic bit0, input logic bit1, input logic c_ext);
        return bit0 | (~c_ext & bit1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a saturating entry count.
// A push on a full stack silently overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    top_r;
    logic [CW-1:0]    count_r;
    logic [PW-1:0]    top_inc_s;

    assign top_inc_s = top_r + PW'(1);
    assign top_data  = mem_r[top_r];
    assign empty     = (count_r == CW'(0));

    // Pointer, count and storage update; push+pop replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_r   <= PW'(0);
            count_r <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (flush) begin
            count_r <= CW'(0);
        end else if (push && pop) begin
            mem_r[top_r] <= push_data;
            if (count_r == CW'(0)) begin
                count_r <= CW'(1);
            end else begin
                count_r <= count_r;
            end
        end else if (push) begin
            top_r            <= top_inc_s;
            mem_r[top_inc_s] <= push_data;
            if (count_r == CW'(DEPTH)) begin
                count_r <= count_r;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else if (pop && (count_r != CW'(0))) begin
            top_r   <= top_r - PW'(1);
            count_r <= count_r - CW'(1);
        end else begin
            top_r   <= top_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC and picks the next one from trap vector,
// execute redirect, return-address prediction or the sequential +2/+4 step.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                  Reg_size  = 32,
    parameter logic [Reg_size-1:0] RESET_VEC = '0,
    parameter int                  RAS_DEPTH = 4,
    parameter bit                  C_EXT     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trap_valid,
    input  logic [Reg_size-1:0] trap_vec,
    input  logic                redirect_valid,
    input  logic [Reg_size-1:0] redirect_pc,
    input  logic                is_compressed,
    input  logic                call,
    input  logic                ret,
    output logic [Reg_size-1:0] pc_out,
    output logic [Reg_size-1:0] pc_plus,
    output logic                misaligned,
    output logic                ras_empty
);

    logic [Reg_size-1:0] pc_r;
    logic [Reg_size-1:0] pc_next_s;
    logic [Reg_size-1:0] step_s;
    logic [Reg_size-1:0] ras_top_s;
    logic                misaligned_r;
    logic                redir_bad_s;
    logic                advance_s;
    logic                ras_empty_s;
    pc_sel_e             sel_s;

    assign step_s      = (C_EXT && is_compressed) ? Reg_size'(STEP_2) : Reg_size'(STEP_4);
    assign pc_plus     = pc_r + step_s;
    assign pc_out      = pc_r;
    assign misaligned  = misaligned_r;
    assign ras_empty   = ras_empty_s;
    assign redir_bad_s = addr_misaligned(redirect_pc[0], redirect_pc[1], C_EXT);
    // The stack only moves on a normal advancing cycle; traps and redirects squash call/ret.
    assign advance_s   = en && !trap_valid && !redirect_valid;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (Reg_size)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (trap_valid),
        .push      (advance_s && call),
        .pop       (advance_s && ret),
        .push_data (pc_plus),
        .top_data  (ras_top_s),
        .empty     (ras_empty_s)
    );

    // Next-PC source priority.
    always_comb begin
        sel_s = SEL_SEQ;
        if (rst) begin
            sel_s = SEL_RESET;
        end else if (trap_valid) begin
            sel_s = SEL_TRAP;
        end else if (redirect_valid) begin
            sel_s = SEL_REDIRECT;
        end else if (!en) begin
            sel_s = SEL_HOLD;
        end else if (ret && !ras_empty_s) begin
            sel_s = SEL_RAS;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next-PC value for the selected source; a rejected redirect keeps the current PC.
    always_comb begin
        pc_next_s = pc_r;
        case (sel_s)
            SEL_RESET:    pc_next_s = RESET_VEC;
            SEL_TRAP:     pc_next_s = {trap_vec[Reg_size-1:2], 2'b00};
            SEL_REDIRECT: pc_next_s = redir_bad_s ? pc_r : redirect_pc;
            SEL_HOLD:     pc_next_s = pc_r;
            SEL_RAS:      pc_next_s = ras_top_s;
            SEL_SEQ:      pc_next_s = pc_plus;
            default:      pc_next_s = pc_r;
        endcase
    end

    // PC register and one-cycle misaligned-redirect flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_VEC;
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            misaligned_r <= (sel_s == SEL_REDIRECT) && redir_bad_s;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (32-bit-only and compressed ISA) share the stimulus;
// a queue-based reference model predicts each instance and a monitor checks the outputs.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp;
        logic        mis;
        logic        emp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, trap_valid = 1'b0, redirect_valid = 1'b0;
    logic        is_compressed = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] trap_vec = 32'h0, redirect_pc = 32'h0;
    logic [31:0] pc_out0, pc_plus0, pc_out1, pc_plus1;
    logic        mis0, mis1, emp0, emp1;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc  [2];
    logic [31:0] m_ras [2][$];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;

    pc_gen #(.Reg_size(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .trap_valid(trap_valid), .trap_vec(trap_vec),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .is_compressed(is_compressed), .call(call), .ret(ret),
        .pc_out(pc_out0), .pc_plus(pc_plus0), .misaligned(mis0), .ras_empty(emp0));

    pc_gen #(.Reg_size(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .trap_valid(trap_valid), .trap_vec(trap_vec),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .is_compressed(is_compressed), .call(call), .ret(ret),
        .pc_out(pc_out1), .pc_plus(pc_plus1), .misaligned(mis1), .ras_empty(emp1));

    // Reference behaviour: PC as a number, RAS as a queue whose back is the top.
    task automatic model(input int k, input bit cext, output exp_t e);
        logic [31:0] stp, plus, tgt;
        logic        mis;
        stp  = (cext && is_compressed) ? 32'd2 : 32'd4;
        plus = m_pc[k] + stp;
        mis  = 1'b0;
        if (rst) begin
            m_pc[k] = 32'h0;
            m_ras[k].delete();
        end else if (trap_valid) begin
            m_pc[k] = trap_vec & 32'hFFFF_FFFC;
            m_ras[k].delete();
        end else if (redirect_valid) begin
            if (redirect_pc[0] || (!cext && redirect_pc[1])) mis = 1'b1;
            else m_pc[k] = redirect_pc;
        end else if (!en) begin
            mis = 1'b0;
        end else if (call && ret) begin
            if (m_ras[k].size() > 0) begin
                tgt = m_ras[k][m_ras[k].size()-1];
                m_ras[k][m_ras[k].size()-1] = plus;
                m_pc[k] = tgt;
            end else begin
                m_ras[k].push_back(plus);
                m_pc[k] = plus;
            end
        end else if (call) begin
            m_ras[k].push_back(plus);
            if (m_ras[k].size() > 4) void'(m_ras[k].pop_front());
            m_pc[k] = plus;
        end else if (ret && m_ras[k].size() > 0) begin
            m_pc[k] = m_ras[k].pop_back();
        end else begin
            m_pc[k] = plus;
        end
        e.pc  = m_pc[k];
        e.pcp = m_pc[k] + stp;
        e.mis = mis;
        e.emp = (m_ras[k].size() == 0);
    endtask

    task automatic clr();
        rst = 1'b0; en = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0;
        is_compressed = 1'b0; call = 1'b0; ret = 1'b0;
        trap_vec = 32'h0; redirect_pc = 32'h0;
    endtask

    // Predict the post-edge state of both instances, queue it, then advance to the next negedge.
    task automatic tick();
        exp_t e0, e1;
        model(0, 1'b0, e0);
        model(1, 1'b1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Monitor: one queued expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0.pc_out", pc_out0, e.pc);
                chk("d0.pc_plus", pc_plus0, e.pcp);
                chk("d0.misaligned", {31'd0, mis0}, {31'd0, e.mis});
                chk("d0.ras_empty", {31'd0, emp0}, {31'd0, e.emp});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.pc_out", pc_out1, e.pc);
                chk("d1.pc_plus", pc_plus1, e.pcp);
                chk("d1.misaligned", {31'd0, mis1}, {31'd0, e.mis});
                chk("d1.ras_empty", {31'd0, emp1}, {31'd0, e.emp});
            end
        end
    end

    initial begin
        m_pc[0] = 32'h0;
        m_pc[1] = 32'h0;
        @(negedge clk);
        // reset then sequential fetch
        clr(); rst = 1'b1; tick(); tick();
        clr(); en = 1'b1; tick(); tick();
        // stall, redirect during stall, trap beats redirect
        clr(); tick();
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h40; tick();
        clr(); trap_valid = 1'b1; trap_vec = 32'h203; redirect_valid = 1'b1; redirect_pc = 32'h80; tick();
        // call/ret round trip
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h10; tick();
        clr(); en = 1'b1; call = 1'b1; tick();
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h100; tick();
        clr(); en = 1'b1; tick();
        clr(); en = 1'b1; ret = 1'b1; tick(); tick();
        // overflow: five calls, five returns
        clr(); rst = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin clr(); en = 1'b1; call = 1'b1; tick(); end
        for (int i = 0; i < 5; i++) begin clr(); en = 1'b1; ret = 1'b1; tick(); end
        // alignment and compressed step
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h102; tick();
        clr(); tick();
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h100; tick();
        clr(); en = 1'b1; is_compressed = 1'b1; tick();
        clr(); en = 1'b1; call = 1'b1; ret = 1'b1; tick();
        // wrap, then reset while stalled with a full stack and a bad redirect pending
        clr(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        clr(); en = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin clr(); en = 1'b1; call = 1'b1; tick(); end
        clr(); redirect_valid = 1'b1; redirect_pc = 32'h3; tick();
        clr(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3; tick();
        clr(); tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr();
            rst            = ($urandom_range(0, 99) == 0);
            trap_valid     = ($urandom_range(0, 19) == 0);
            trap_vec       = $urandom;
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) redirect_pc[31:4] = 28'hFFF_FFFF;
            en             = ($urandom_range(0, 3) != 0);
            is_compressed  = $urandom_range(0, 1);
            call           = ($urandom_range(0, 3) == 0);
            ret            = ($urandom_range(0, 3) == 0);
            tick();
        end
        clr(); tick();
        @(posedge clk); #2;
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
